tff_counter_sequencer: RTL and testbench
========================================

// Module: tff_counter_sequencer
// PURPOSE
//  Controller that sequences a bank of WIDTH posedge T flip-flops with async reset as a counter.
//  Only the per-bit toggle vector t_vec is computed; all count storage lives in the T-FF bank.
//  Supports up/down, a latched modulus, free-run or one-shot, and pause/resume.
//  Sits between control logic (start/stop handshake) and the T-FF datapath.
// PARAMETERS
//  WIDTH  4  bits in the T-FF bank / count width (>=1)
// PORTS
//  clk          in   1      posedge clock, single clock domain
//  reset_async  in   1      asynchronous, active-low reset
//  start        in   1      level, sampled each posedge: begin (IDLE) / resume (HOLD)
//  stop         in   1      level, sampled each posedge: pause (RUN) / abort (HOLD)
//  dir_up       in   1      1=count up, 0=down; latched on start from IDLE
//  cnt_max      in   WIDTH  terminal value; latched on start from IDLE
//  oneshot      in   1      1=stop at terminal, 0=wrap; latched on start from IDLE
//  count        out  WIDTH  T-FF bank outputs (Q vector)
//  busy         out  1      high in RUN or HOLD
//  wrap         out  1      1-cycle pulse on the cycle count wraps
//  done         out  1      1-cycle pulse, one-shot completion
//  chk_err      out  1      shadow mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_async=0, async): count=0, state=IDLE, busy=0, wrap=0, done=0, chk_err=0, latches=0.
//  Counting: all T-FF writes use t_vec = count ^ next_count. t_vec=0 holds the count.
//  FSM states: IDLE, RUN, HOLD, DONE.
//   IDLE: t_vec=0.
//    On start=1, stop=0: latch dir_up, cnt_max, oneshot.
//    On that same edge, count loads 0 (up) or cnt_max (down). Next state is RUN.
//    busy rises on the cycle after start is sampled.
//   RUN: count steps by 1 every cycle in the latched direction.
//    Up terminal (count==max_l), oneshot=0: next is 0, wrap=1.
//    Down terminal (count==0), oneshot=0: next is max_l, wrap=1.
//    Terminal with oneshot=1: count holds at terminal, next state DONE, no wrap.
//    stop=1: count freezes, next state HOLD. stop has priority over a terminal step.
//   HOLD: t_vec=0.
//    stop=1: go to IDLE, count retained.
//    else start=1: go to RUN, resume from the held count.
//   DONE: done=1 for exactly one cycle, t_vec=0, then IDLE. start is ignored in DONE.
//  Simultaneous start & stop: stop wins in every state.
//    In IDLE both high means stay in IDLE and do not latch.
//  cnt_max, dir_up, oneshot changes while busy are ignored until the next start from IDLE.
//  max_l=0: count stays 0.
//    Free-run: wrap pulses every RUN cycle.
//    One-shot: DONE after 1 RUN cycle.
//  Arithmetic is modulo 2^WIDTH, and the terminal compare takes precedence.
//  wrap and done are registered outputs, never both high in the same cycle.
//  Reset mid-RUN/HOLD: immediate return to reset values. No pulse is emitted.
// CONFIGURATION
//  TFF_SEQ_SHADOW_CHECK_EN defined:
//   A binary shadow register tracks the expected next_count each cycle.
//   chk_err is set (sticky until reset) on the first cycle count != shadow.
//  TFF_SEQ_SHADOW_CHECK_EN undefined: no shadow logic, chk_err tied 0.
// STRUCTURE
//  Package tff_seq_pkg holds the state_t enum (IDLE, RUN, HOLD, DONE; 2-bit encoding)
//    and localparam ST_W=2.
//  Sub-module tff_cell: one posedge T flip-flop, async active-low reset to 0.
//    It is instantiated WIDTH times via generate.
//  The sequencer holds the FSM, the latches, the next_count/t_vec logic and pulse generation.
// TESTING
//  1 WIDTH=4: up, max=5, free-run, start 1 cycle -> count 0,1,2,3,4,5,0; wrap on the 5->0 cycle; busy=1.
//  2 Down, max=3, oneshot -> count 3,2,1,0 then holds 0; done pulses 1 cycle; busy falls; no wrap.
//  3 Up, RUN at count=2, stop 1 cycle -> HOLD, count stays 2.
//    start -> resumes 3. A second stop in HOLD -> IDLE, count stays put.
//  4 start=stop=1 in IDLE -> stays IDLE, busy=0, count unchanged, no latch.
//  5 reset_async=0 mid-RUN at count=9 (max=12) -> count=0 and busy=0 immediately, before the next edge.
//  6 Up, max=0, free-run -> count stays 0, wrap high every RUN cycle.
//    With TFF_SEQ_SHADOW_CHECK_EN defined, chk_err stays 0 across scenarios 1-6.

Source files
------------

// File: rtl/tff_seq_pkg.sv
// Shared types for the T flip-flop counter sequencer.
// Holds the 2-bit FSM state encoding used by tff_counter_sequencer.
package tff_seq_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single posedge T flip-flop with asynchronous active-low reset to 0.
// One instance per count bit; the sequencer only ever drives its toggle input.
module tff_cell (
  input  logic clk,
  input  logic reset_async,
  input  logic t,
  output logic q
);

  // Toggle the stored bit whenever t is high, clear it on reset.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_counter_sequencer.sv
// Counter sequencer driving a bank of WIDTH T flip-flops.
// The bank holds the count; this module only computes the per-bit toggle
// vector (t_vec = count ^ next_count) plus the FSM, latches and pulses.
// Optional build macro: TFF_SEQ_SHADOW_CHECK_EN adds a binary shadow of the
// expected count and a sticky chk_err flag on any divergence.
module tff_counter_sequencer
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_up,
  input  logic [WIDTH-1:0] cnt_max,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             chk_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_reg;
  logic             dir_l_reg;
  logic [WIDTH-1:0] max_l_reg;
  logic             one_l_reg;
  logic             busy_reg;
  logic             wrap_reg;
  logic             done_reg;

  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] t_vec;
  logic             load_go;
  logic             terminal;

  // T-FF bank: each bit toggles where the next count differs from the present one.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
        .clk         (clk),
        .reset_async (reset_async),
        .t           (t_vec[gi]),
        .q           (count[gi])
      );
    end
  endgenerate

  // Next count: load on start from IDLE, step/wrap in RUN, hold everywhere else.
  always_comb begin
    count_next = count;
    load_go    = (state_reg == IDLE) && start && !stop;
    // Terminal compare wins over plain stepping (covers max_l == 0).
    terminal   = dir_l_reg ? (count == max_l_reg) : (count == '0);
    case (state_reg)
      IDLE: begin
        if (load_go) begin
          count_next = dir_up ? '0 : cnt_max;
        end
      end
      RUN: begin
        if (!stop) begin
          if (terminal) begin
            if (!one_l_reg) begin
              count_next = dir_l_reg ? '0 : max_l_reg;
            end
          end else begin
            count_next = dir_l_reg ? (count + ONE) : (count - ONE);
          end
        end
      end
      default: count_next = count;
    endcase
    t_vec = count ^ count_next;
  end

  // FSM with latched configuration and registered busy/wrap/done outputs.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      state_reg <= IDLE;
      dir_l_reg <= 1'b0;
      max_l_reg <= '0;
      one_l_reg <= 1'b0;
      busy_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_go) begin
            dir_l_reg <= dir_up;
            max_l_reg <= cnt_max;
            one_l_reg <= oneshot;
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= HOLD;
          end else if (terminal) begin
            if (one_l_reg) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              wrap_reg <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (start) begin
            state_reg <= RUN;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign wrap = wrap_reg;
  assign done = done_reg;

`ifdef TFF_SEQ_SHADOW_CHECK_EN
  logic [WIDTH-1:0] shadow_reg;
  logic             chk_err_reg;

  // Binary shadow of the intended count; flag sticks on the first divergence.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      shadow_reg  <= '0;
      chk_err_reg <= 1'b0;
    end else begin
      shadow_reg <= count_next;
      if (count != shadow_reg) begin
        chk_err_reg <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_reg;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_tff_counter_sequencer.sv
// Self-checking bench for tff_counter_sequencer (WIDTH=4).
// Directed scenarios followed by a randomized phase, all compared against a
// cycle-level behavioural model of the counter rules.
module tb_tff_counter_sequencer;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk_tb;
  logic         reset_async;
  logic         start;
  logic         stop;
  logic         dir_up;
  logic [W-1:0] cnt_max;
  logic         oneshot;
  logic [W-1:0] count;
  logic         busy;
  logic         wrap;
  logic         done;
  logic         chk_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain integers and flags.
  int m_count;
  bit m_active;
  bit m_paused;
  bit m_finish;
  bit m_dir;
  int m_max;
  bit m_one;
  bit m_wrap;

  tff_counter_sequencer #(.WIDTH(W)) dut (
    .clk         (clk_tb),
    .reset_async (reset_async),
    .start       (start),
    .stop        (stop),
    .dir_up      (dir_up),
    .cnt_max     (cnt_max),
    .oneshot     (oneshot),
    .count       (count),
    .busy        (busy),
    .wrap        (wrap),
    .done        (done),
    .chk_err     (chk_err)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] exp_cnt;
    exp_cnt = W'(m_count);
    check({tag, ".count"},   int'(count),   int'(exp_cnt));
    check({tag, ".busy"},    int'(busy),    int'(m_active || m_paused));
    check({tag, ".wrap"},    int'(wrap),    int'(m_wrap));
    check({tag, ".done"},    int'(done),    int'(m_finish));
    check({tag, ".chk_err"}, int'(chk_err), 0);
    $display("t=%0t %s start=%0b stop=%0b count=%0d busy=%0b wrap=%0b done=%0b",
             $time, tag, start, stop, count, busy, wrap, done);
  endtask

  function automatic void model_reset();
    m_count  = 0;
    m_active = 0;
    m_paused = 0;
    m_finish = 0;
    m_dir    = 0;
    m_max    = 0;
    m_one    = 0;
    m_wrap   = 0;
  endfunction

  // One clock edge of the counter rules, applied to the sampled inputs.
  function automatic void model_edge(input bit s, input bit p, input bit d,
                                     input int mx, input bit o);
    bit at_end;
    m_wrap = 0;
    if (m_finish) begin
      m_finish = 0;
    end else if (m_paused) begin
      if (p) m_paused = 0;
      else if (s) begin
        m_paused = 0;
        m_active = 1;
      end
    end else if (m_active) begin
      at_end = m_dir ? (m_count == m_max) : (m_count == 0);
      if (p) begin
        m_active = 0;
        m_paused = 1;
      end else if (at_end) begin
        if (m_one) begin
          m_active = 0;
          m_finish = 1;
        end else begin
          m_count = m_dir ? 0 : m_max;
          m_wrap  = 1;
        end
      end else begin
        m_count = m_dir ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
      end
    end else if (s && !p) begin
      m_dir    = d;
      m_max    = mx;
      m_one    = o;
      m_count  = d ? 0 : mx;
      m_active = 1;
    end
  endfunction

  task automatic step(input string tag, input bit s, input bit p, input bit d,
                      input int mx, input bit o);
    start   = s;
    stop    = p;
    dir_up  = d;
    cnt_max = W'(mx);
    oneshot = o;
    @(posedge clk_tb);
    model_edge(s, p, d, mx, o);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    reset_async = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #2;
    reset_async = 1'b1;
  endtask

  initial begin
    reset_async = 1'b0;
    start = 0; stop = 0; dir_up = 0; cnt_max = '0; oneshot = 0;
    model_reset();
    #12;
    check_all("reset");
    reset_async = 1'b1;
    @(posedge clk_tb);
    #1;

    // 1: up, max=5, free-run; expect 0..5 then wrap to 0
    step("s1_start", 1, 0, 1, 5, 0);
    for (int i = 0; i < 7; i++) step("s1_run", 0, 0, 0, 9, 1);

    // 2: down, max=3, one-shot; expect 3,2,1,0, done, idle
    step("s2_stop", 0, 1, 0, 0, 0);
    step("s2_abort", 0, 1, 0, 0, 0);
    step("s2_start", 1, 0, 0, 3, 1);
    for (int i = 0; i < 6; i++) step("s2_run", (i == 4), 0, 1, 7, 0);

    // 3: up, stop at 2, resume, stop twice to leave
    step("s3_start", 1, 0, 1, 9, 0);
    step("s3_run", 0, 0, 0, 0, 0);
    step("s3_run", 0, 0, 0, 0, 0);
    step("s3_pause", 0, 1, 0, 0, 0);
    step("s3_hold", 0, 0, 0, 0, 0);
    step("s3_resume", 1, 0, 0, 0, 0);
    step("s3_run", 0, 0, 0, 0, 0);
    step("s3_pause", 0, 1, 0, 0, 0);
    step("s3_abort", 0, 1, 0, 0, 0);
    step("s3_idle", 0, 0, 0, 0, 0);

    // 4: start and stop together in IDLE; nothing latched or loaded
    step("s4_both", 1, 1, 0, 11, 1);
    step("s4_both", 1, 1, 1, 2, 0);
    step("s4_idle", 0, 0, 0, 0, 0);

    // 5: reset mid-RUN at count 9, max 12
    step("s5_start", 1, 0, 1, 12, 0);
    for (int i = 0; i < 9; i++) step("s5_run", 0, 0, 0, 0, 0);
    async_reset("s5_reset");
    step("s5_idle", 0, 0, 0, 0, 0);

    // 6: up, max=0, free-run; wrap every RUN cycle
    step("s6_start", 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("s6_run", 0, 0, 1, 6, 1);
    step("s6_pause", 0, 1, 0, 0, 0);
    step("s6_abort", 0, 1, 0, 0, 0);
    // max=0 one-shot: DONE after one RUN cycle
    step("s6_one", 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("s6_one_run", 0, 0, 0, 0, 0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_reset");
      end
      step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
